exp_adder_pipe: RTL and testbench

// - Pipelined, parametrised exponent adder for the fused array multiplier datapath.
// - Computes the biased product exponent: a_exp + b_exp + norm_inc - BIAS.
// - Flags overflow, underflow, zero operands and inf/NaN operands.
// - Two register stages with valid/ready flow control; sits in parallel with the mantissa array.

---
 rtl/fp_mul_pkg.sv | 20 ++
 rtl/exp_pipe_reg.sv | 37 +++
 rtl/exp_adder_pipe.sv | 98 +++++++++
 tb/tb_exp_adder_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the fused multiplier datapath.
// Exponent-path flags and the all-ones helper live here so every stage agrees on them.
package fp_mul_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int BIAS_DEF  = 127;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero_op;
        logic inf_op;
    } exp_flags_t;

    // Intended for widths below 32.
    function automatic int unsigned EXP_ALL_ONES(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/exp_pipe_reg.sv
// Generic valid/ready register slice; accepts a new word whenever it is empty
// or its current word is being taken downstream in the same cycle.
module exp_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_up_valid,
    input  logic [W-1:0] i_up_data,
    output logic         o_up_ready,
    output logic         o_dn_valid,
    output logic [W-1:0] o_dn_data,
    input  logic         i_dn_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign o_up_ready = !r_valid || i_dn_ready;
    assign w_load     = i_up_valid && o_up_ready;
    assign o_dn_valid = r_valid;
    assign o_dn_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_up_data;
        end else if (i_dn_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/exp_adder_pipe.sv
// Two-stage biased exponent adder: S1 registers the raw sum and special-operand
// detection, S2 removes the bias and resolves range flags and the final exponent.
module exp_adder_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W    = EXP_W_DEF,
    parameter int BIAS     = BIAS_DEF,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    input  logic             norm_inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] sum_exp,
    output logic             ovf,
    output logic             unf,
    output logic             zero_op,
    output logic             inf_op
);

    localparam int RAW_W = EXP_W + 2;
    localparam int S1_W  = RAW_W + 2;
    localparam int S2_W  = EXP_W + $bits(exp_flags_t);
    localparam logic [EXP_W-1:0] ALL1 = EXP_W'(EXP_ALL_ONES(EXP_W));

    logic [RAW_W-1:0]        w_raw_in;
    logic                    w_z_in, w_i_in;
    logic                    w_s1_valid, w_s1_ready;
    logic [S1_W-1:0]         w_s1_data;
    logic [RAW_W-1:0]        w_s1_raw;
    logic                    w_s1_z, w_s1_i;
    logic signed [RAW_W-1:0] w_r;
    logic [EXP_W-1:0]        w_sum;
    exp_flags_t              w_flags;
    exp_flags_t              w_out_flags;
    logic [S2_W-1:0]         w_s2_data;

    // Widened to EXP_W+2 so the sum and the later bias subtraction never lose bits.
    assign w_raw_in = RAW_W'(a_exp) + RAW_W'(b_exp) + RAW_W'(norm_inc);
    assign w_z_in   = (a_exp == '0) || (b_exp == '0);
    assign w_i_in   = (a_exp == ALL1) || (b_exp == ALL1);

    exp_pipe_reg #(.W(S1_W)) u_s1 (
        .clk        (clk),
        .rst        (rst),
        .i_up_valid (in_valid),
        .i_up_data  ({w_raw_in, w_z_in, w_i_in}),
        .o_up_ready (in_ready),
        .o_dn_valid (w_s1_valid),
        .o_dn_data  (w_s1_data),
        .i_dn_ready (w_s1_ready)
    );

    assign {w_s1_raw, w_s1_z, w_s1_i} = w_s1_data;
    assign w_r = $signed(w_s1_raw) - $signed(RAW_W'(BIAS));

    always_comb begin
        w_flags         = '0;
        w_flags.zero_op = w_s1_z;
        w_flags.inf_op  = w_s1_i;
        w_sum           = w_r[EXP_W-1:0];
        if (w_s1_i) begin
            w_sum = ALL1;
        end else if (w_s1_z) begin
            w_sum = '0;
        end else begin
            w_flags.ovf = (w_r >= $signed({2'b00, ALL1}));
            w_flags.unf = (w_r <= 0);
            if (SATURATE != 0) begin
                if (w_flags.ovf)      w_sum = ALL1;
                else if (w_flags.unf) w_sum = '0;
            end
        end
    end

    exp_pipe_reg #(.W(S2_W)) u_s2 (
        .clk        (clk),
        .rst        (rst),
        .i_up_valid (w_s1_valid),
        .i_up_data  ({w_sum, w_flags}),
        .o_up_ready (w_s1_ready),
        .o_dn_valid (out_valid),
        .o_dn_data  (w_s2_data),
        .i_dn_ready (out_ready)
    );

    assign {sum_exp, w_out_flags} = w_s2_data;
    assign ovf     = w_out_flags.ovf;
    assign unf     = w_out_flags.unf;
    assign zero_op = w_out_flags.zero_op;
    assign inf_op  = w_out_flags.inf_op;

endmodule

// File: tb/tb_exp_adder_pipe.sv
// Bench for exp_adder_pipe: directed corner cases, a wrap-mode build, backpressure,
// randomized traffic against a queue-based reference, and mid-stream reset.
module tb_exp_adder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, norm_inc, out_valid, out_ready;
    logic       ovf, unf, zero_op, inf_op;
    logic [7:0] a_exp, b_exp, sum_exp;
    logic       z_in_valid, z_in_ready, z_norm_inc, z_out_valid, z_out_ready;
    logic       z_ovf, z_unf, z_zero_op, z_inf_op;
    logic [7:0] z_a_exp, z_b_exp, z_sum_exp;
    logic [11:0] w_act, w_zact;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] q[$];

    exp_adder_pipe #(.EXP_W(8), .BIAS(127), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_exp(a_exp), .b_exp(b_exp), .norm_inc(norm_inc),
        .out_valid(out_valid), .out_ready(out_ready), .sum_exp(sum_exp),
        .ovf(ovf), .unf(unf), .zero_op(zero_op), .inf_op(inf_op)
    );

    exp_adder_pipe #(.EXP_W(8), .BIAS(127), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .a_exp(z_a_exp), .b_exp(z_b_exp), .norm_inc(z_norm_inc),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .sum_exp(z_sum_exp),
        .ovf(z_ovf), .unf(z_unf), .zero_op(z_zero_op), .inf_op(z_inf_op)
    );

    assign w_act  = {sum_exp, ovf, unf, zero_op, inf_op};
    assign w_zact = {z_sum_exp, z_ovf, z_unf, z_zero_op, z_inf_op};

    // Reference: {sum_exp, ovf, unf, zero_op, inf_op} from plain integer arithmetic.
    function automatic logic [11:0] ref_exp(input int a, input int b, input int inc, input bit sat);
        int r, s;
        bit z, i, ov, un;
        r  = a + b + inc - 127;
        z  = (a == 0) || (b == 0);
        i  = (a == 255) || (b == 255);
        ov = 1'b0;
        un = 1'b0;
        if (i)      s = 255;
        else if (z) s = 0;
        else begin
            ov = (r >= 255);
            un = (r <= 0);
            s  = r & 255;
            if (sat && ov) s = 255;
            if (sat && un) s = 0;
        end
        return {s[7:0], ov, un, z, i};
    endfunction

    function automatic int rnd_exp();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a_exp = '0; b_exp = '0; norm_inc = 1'b0;
        z_in_valid = 1'b0; z_out_ready = 1'b0; z_a_exp = '0; z_b_exp = '0; z_norm_inc = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (w_act !== 12'h000) begin n_err++; $display("FAIL reset_data: got %h want 000", w_act); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (z_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_wrap_out_valid: got %b want 0", z_out_valid); end
    endtask

    task automatic test_directed();
        int va[11]  = '{130, 254, 200, 64, 63, 63,   0, 255,   0, 255, 1};
        int vb[11]  = '{131, 127, 182, 64, 64, 64, 200,  10, 255, 255, 1};
        int vi[11]  = '{  0,   0,   0,  0,  0,  1,   0,   0,   0,   1, 1};
        logic [11:0] exp_v;
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            exp_v = ref_exp(va[k], vb[k], vi[k], 1'b1);
            in_valid = 1'b1; a_exp = 8'(va[k]); b_exp = 8'(vb[k]); norm_inc = vi[k][0];
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready: got %b want 1", k, in_ready); end
            step();
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_latency1: got out_valid %b want 0", k, out_valid); end
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_latency2: got out_valid %b want 1", k, out_valid); end
            n_cmp++; if (w_act !== exp_v) begin n_err++; $display("FAIL dir%0d_result a=%0d b=%0d inc=%0d: got %h want %h", k, va[k], vb[k], vi[k], w_act, exp_v); end
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_drained: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        int va[4] = '{200, 50, 130,   0};
        int vb[4] = '{200, 50, 131, 255};
        logic [11:0] exp_v;
        z_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_v = ref_exp(va[k], vb[k], 0, 1'b0);
            z_in_valid = 1'b1; z_a_exp = 8'(va[k]); z_b_exp = 8'(vb[k]); z_norm_inc = 1'b0;
            step();
            z_in_valid = 1'b0;
            step();
            n_cmp++; if (z_out_valid !== 1'b1) begin n_err++; $display("FAIL wrap%0d_valid: got %b want 1", k, z_out_valid); end
            n_cmp++; if (w_zact !== exp_v) begin n_err++; $display("FAIL wrap%0d_result a=%0d b=%0d: got %h want %h", k, va[k], vb[k], w_zact, exp_v); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int va[3], vb[3];
        int k = 0;
        logic [11:0] exp_v;
        for (int j = 0; j < 3; j++) begin
            va[j] = int'($urandom_range(1, 254));
            vb[j] = int'($urandom_range(1, 254));
        end
        q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; a_exp = 8'(va[k]); b_exp = 8'(vb[k]); norm_inc = 1'b0;
            @(negedge clk);
            n_cmp++; if (in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL b2b_cap%0d: got in_ready %b want %b", c, in_ready, q.size() < 2); end
            if (in_valid && in_ready && k < 3) begin q.push_back(ref_exp(va[k], vb[k], 0, 1'b1)); k++; end
            step();
        end
        n_cmp++; if (k !== 2) begin n_err++; $display("FAIL b2b_accepted: got %0d want 2", k); end
        n_cmp++; if (!(out_valid === 1'b1 && q.size() > 0 && w_act === q[0])) begin
            n_err++; $display("FAIL b2b_stall_hold: got valid %b data %h want valid 1 data %h", out_valid, w_act, q.size() > 0 ? q[0] : 12'h0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (k < 3);
            if (k < 3) begin a_exp = 8'(va[k]); b_exp = 8'(vb[k]); end
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL b2b_extra: got %h want nothing", w_act); end
                else begin
                    exp_v = q.pop_front();
                    if (w_act !== exp_v) begin n_err++; $display("FAIL b2b_order: got %h want %h", w_act, exp_v); end
                end
            end
            if (in_valid && in_ready) begin q.push_back(ref_exp(va[k], vb[k], 0, 1'b1)); k++; end
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (q.size() != 0 || k != 3) begin n_err++; $display("FAIL b2b_loss: got %0d pending %0d sent want 0 pending 3 sent", q.size(), k); end
    endtask

    task automatic test_random();
        logic [11:0] exp_v;
        int a, b, inc;
        q.delete();
        for (int c = 0; c < 500; c++) begin
            a = rnd_exp(); b = rnd_exp(); inc = int'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = (c >= 480) || ($urandom_range(0, 9) < 6);
            a_exp = 8'(a); b_exp = 8'(b); norm_inc = inc[0];
            @(negedge clk);
            n_cmp++; if (in_ready !== (q.size() < 2 || out_ready)) begin
                n_err++; $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, q.size() < 2 || out_ready);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL rnd_extra c=%0d: got %h want nothing", c, w_act); end
                else begin
                    exp_v = q.pop_front();
                    if (w_act !== exp_v) begin n_err++; $display("FAIL rnd_data c=%0d: got %h want %h", c, w_act, exp_v); end
                end
            end
            if (c >= 480) in_valid = 1'b0;
            if (in_valid && in_ready) q.push_back(ref_exp(a, b, inc, 1'b1));
            step();
        end
        n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d pending want 0", q.size()); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; a_exp = 8'd140; b_exp = 8'd150; norm_inc = 1'b0;
        repeat (3) step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (w_act !== 12'h000) begin n_err++; $display("FAIL mrst_data: got %h want 000", w_act); end
        rst = 1'b0; out_ready = 1'b1;
        q.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_stale%0d: got out_valid %b want 0", c, out_valid); end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_wrap();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
